// File: rtl/user_obi_burst_reader.sv
// OBI read-only manager: fetches a burst of consecutive words into a small FIFO.
// One outstanding transaction; a FIFO slot is reserved before each request.
module user_obi_burst_reader #(
  parameter int unsigned ADDR_WIDTH_OBI = 32,
  parameter int unsigned DATA_WIDTH_OBI = 32,
  parameter int unsigned ID_WIDTH_OBI   = 1,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [ADDR_WIDTH_OBI-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]      count_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      req_o,
  output logic                      we_o,
  output logic [3:0]                be_o,
  output logic [ADDR_WIDTH_OBI-1:0] addr_o,
  output logic [DATA_WIDTH_OBI-1:0] wdata_o,
  output logic [ID_WIDTH_OBI-1:0]   aid_o,
  input  logic                      gnt_i,
  input  logic                      rvalid_i,
  input  logic [DATA_WIDTH_OBI-1:0] rdata_i,
  input  logic [ID_WIDTH_OBI-1:0]   rid_i,
  input  logic                      err_i,
  output logic                      data_valid_o,
  output logic [DATA_WIDTH_OBI-1:0] data_o,
  input  logic                      data_ready_i
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R
  } state_e;

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH_OBI-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]      rem_q, rem_d;
  logic                      err_q, err_d;
  logic                      done_q, done_d;
  logic [DATA_WIDTH_OBI-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]             wptr_q, rptr_q;
  logic [PW:0]               cnt_q;
  logic                      push, pop, rsp_ok;

  assign rsp_ok = !err_i && (rid_i == '0);
  assign pop    = data_ready_i && (cnt_q != '0);
  assign req_o  = (state_q == REQ) && (cnt_q < FULL);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    err_d   = err_q;
    done_d  = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d = base_addr_i & ~ADDR_WIDTH_OBI'(3);
          rem_d  = count_i;
          err_d  = 1'b0;
          if (count_i == '0) done_d = 1'b1;
          else               state_d = REQ;
        end
      end
      REQ: begin
        if (req_o && gnt_i) state_d = WAIT_R;
      end
      WAIT_R: begin
        if (rvalid_i) begin
          if (rsp_ok) begin
            push   = 1'b1;
            rem_d  = rem_q - CNT_WIDTH'(1);
            addr_d = addr_q + ADDR_WIDTH_OBI'(4);
            if (rem_q == CNT_WIDTH'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = REQ;
            end
          end else begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      done_q  <= done_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (PW+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (PW+1)'(1);
    end
  end

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= rdata_i;
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign we_o         = 1'b0;
  assign be_o         = 4'hF;
  assign addr_o       = addr_q;
  assign wdata_o      = '0;
  assign aid_o        = '0;
  assign data_valid_o = (cnt_q != '0);
  assign data_o       = mem_q[rptr_q];

endmodule

// File: tb/tb_user_obi_burst_reader.sv
// Randomised bench for user_obi_burst_reader: subordinate model plus
// scoreboard of expected addresses/words checked by a negedge monitor.
module tb_user_obi_burst_reader;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [7:0]  count_i;
  logic        busy_o, done_o, err_o, req_o, we_o;
  logic [3:0]  be_o;
  logic [31:0] addr_o, wdata_o;
  logic [0:0]  aid_o;
  logic        gnt_i, rvalid_i, err_i;
  logic [31:0] rdata_i;
  logic [0:0]  rid_i;
  logic        data_valid_o;
  logic [31:0] data_o;
  logic        data_ready_i;

  always #5 clk = ~clk;

  user_obi_burst_reader dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .count_i(count_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .aid_o(aid_o), .gnt_i(gnt_i),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .rid_i(rid_i),
    .err_i(err_i), .data_valid_o(data_valid_o), .data_o(data_o),
    .data_ready_i(data_ready_i)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic exp_err = 1'b0;
  int done_cnt = 0, gnt_cnt = 0, n_jobs = 0;

  int job_err_at = 1000, resp_idx = 0;
  int gdly = -1, rdly = 0, gnt_fix = -1, rsp_fix = -1, ready_mode = 0;
  bit rsp_pend = 0, last_hs = 0;
  logic [31:0] rsp_addr, hs_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Subordinate model: random grant delay, response 1..3 cycles after grant.
  always @(posedge clk) begin
    #1;
    if (last_hs) begin
      rsp_pend = 1;
      rsp_addr = hs_addr;
      rdly = (rsp_fix >= 0) ? rsp_fix : $urandom_range(0, 2);
    end
    rvalid_i = 0; err_i = 0; rid_i = 0; rdata_i = '0;
    if (rsp_pend) begin
      if (rdly == 0) begin
        rvalid_i = 1;
        rdata_i  = mem_word(rsp_addr);
        if (resp_idx == job_err_at) begin
          if ($urandom_range(0, 1) == 1) err_i = 1;
          else rid_i = 1'b1;
        end
        resp_idx++;
        rsp_pend = 0;
      end else rdly--;
    end
    gnt_i = 0;
    if (req_o) begin
      if (gdly < 0) gdly = (gnt_fix >= 0) ? gnt_fix : $urandom_range(0, 3);
      gnt_i = (gdly == 0);
      if (gdly > 0) gdly--;
      if (gnt_i) gdly = -1;
    end else gdly = -1;
    last_hs = req_o && gnt_i;
    hs_addr = addr_o;
    data_ready_i = (ready_mode == 1) ? 1'b0 :
                   (ready_mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares handshakes against the scoreboard queues.
  logic prev_req = 0, prev_gnt = 0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!rst_i) begin
      if (prev_req && !prev_gnt) begin
        check("req_hold", {31'b0, req_o}, 32'd1);
        check("addr_hold", addr_o, prev_addr);
      end
      if (req_o && gnt_i) begin
        gnt_cnt++;
        if (exp_addr_q.size() == 0) fail_now("extra_grant");
        else check("addr", addr_o, exp_addr_q.pop_front());
      end
      if (data_valid_o && data_ready_i) begin
        if (exp_data_q.size() == 0) fail_now("extra_word");
        else check("data", data_o, exp_data_q.pop_front());
      end
      if (done_o) begin
        done_cnt++;
        check("done_busy", {31'b0, busy_o}, 32'd0);
        check("done_err", {31'b0, err_o}, {31'b0, exp_err});
      end
    end
    prev_req  = req_o && !rst_i;
    prev_gnt  = gnt_i;
    prev_addr = addr_o;
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy_o || done_o) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) fail_now("timeout_idle");
  endtask

  task automatic start_job(input logic [31:0] base, input int cnt,
                           input int err_at);
    logic [31:0] a;
    wait_idle();
    exp_err = (err_at < cnt);
    for (int i = 0; i < cnt; i++) begin
      a = (base & 32'hFFFF_FFFC) + 32'(4 * i);
      if (i <= err_at) exp_addr_q.push_back(a);
      if (i < err_at)  exp_data_q.push_back(mem_word(a));
    end
    job_err_at = err_at;
    resp_idx   = 0;
    n_jobs++;
    base_addr_i = base;
    count_i     = 8'(cnt);
    start_i     = 1;
    @(posedge clk); #1;
    start_i = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req",   {31'b0, req_o},        32'd0);
    check("rst_busy",  {31'b0, busy_o},       32'd0);
    check("rst_done",  {31'b0, done_o},       32'd0);
    check("rst_err",   {31'b0, err_o},        32'd0);
    check("rst_valid", {31'b0, data_valid_o}, 32'd0);
    check("rst_addr",  addr_o,                32'd0);
  endtask

  int g0, n;
  int cnt_r, err_r;

  initial begin
    rst_i = 1; start_i = 0; base_addr_i = '0; count_i = '0;
    gnt_i = 0; rvalid_i = 0; err_i = 0; rdata_i = '0; rid_i = '0;
    data_ready_i = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_i = 0;

    ready_mode = 2; gnt_fix = 0; rsp_fix = 0;
    start_job(32'h2000_0000, 3, 1000);
    wait_idle();

    gnt_fix = 3;
    g0 = gnt_cnt;
    start_job(32'h2000_0100, 1, 1000);
    wait_idle();
    check("one_grant", 32'(gnt_cnt - g0), 32'd1);

    gnt_fix = 0; ready_mode = 1;
    g0 = gnt_cnt;
    start_job(32'h3000_0000, 6, 1000);
    repeat (30) begin @(posedge clk); #1; end
    check("full_grants", 32'(gnt_cnt - g0), 32'd4);
    check("full_noreq", {31'b0, req_o}, 32'd0);
    check("full_busy", {31'b0, busy_o}, 32'd1);
    ready_mode = 2;
    wait_idle();
    check("all_grants", 32'(gnt_cnt - g0), 32'd6);

    ready_mode = 1;
    start_job(32'h3000_1000, 4, 1);
    wait_idle();
    check("abort_err", {31'b0, err_o}, 32'd1);
    check("abort_valid", {31'b0, data_valid_o}, 32'd1);
    check("abort_words", 32'(exp_data_q.size()), 32'd1);
    ready_mode = 2;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_drained", {31'b0, data_valid_o}, 32'd0);
    check("err_sticky", {31'b0, err_o}, 32'd1);

    start_job(32'h1234_5678, 0, 1000);
    check("zero_done", {31'b0, done_o}, 32'd1);
    check("zero_noreq", {31'b0, req_o}, 32'd0);
    check("zero_errclr", {31'b0, err_o}, 32'd0);
    wait_idle();

    start_job(32'hFFFF_FFFE, 2, 1000);
    wait_idle();

    gnt_fix = -1; rsp_fix = -1; ready_mode = 0;
    repeat (25) begin
      cnt_r = $urandom_range(0, 9);
      err_r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, cnt_r) : 1000;
      start_job($urandom, cnt_r, err_r);
      if (busy_o) begin
        base_addr_i = $urandom; count_i = 8'd3; start_i = 1;
        @(posedge clk); #1;
        start_i = 0;
      end
      wait_idle();
    end

    ready_mode = 2; gnt_fix = 0; rsp_fix = 2;
    start_job(32'h4000_0000, 4, 1000);
    n = 0;
    while (!(busy_o && !req_o) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) fail_now("timeout_wait_r");
    rst_i = 1;
    @(posedge clk); #1;
    rst_i = 0;
    check_reset_outputs();
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_err = 0;
    n_jobs--;
    repeat (5) begin @(posedge clk); #1; end
    check("late_rsp_valid", {31'b0, data_valid_o}, 32'd0);
    check("late_rsp_busy", {31'b0, busy_o}, 32'd0);

    rsp_fix = -1;
    start_job(32'h5000_0000, 2, 1000);
    wait_idle();
    repeat (10) begin @(posedge clk); #1; end
    check("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    check("data_q_empty", 32'(exp_data_q.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'(n_jobs));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
